// File: rtl/ram_io_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : ram_io_responder_pkg
// Purpose : Shared I/O map constants, queue defaults and I/O decode helper.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_io_responder_pkg;

    localparam logic [1:0]  IO_SEL       = 2'b11;
    localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

    localparam int TXQ_DEPTH_DEFAULT   = 8;
    localparam int FULL_MARGIN_DEFAULT = 2;

    typedef enum logic [1:0] {
        IO_REG_NONE = 2'd0,
        IO_REG_PORT = 2'd1,
        IO_REG_CLK  = 2'd2,
        IO_REG_SNAP = 2'd3
    } io_reg_e;

    // 0x30005..0x30007 share the counter word with 0x30004.
    function automatic io_reg_e decode_io(input logic [17:0] addr);
        if (addr == IO_PORT_ADDR)
            return IO_REG_PORT;
        if (addr == IO_CLK_ADDR)
            return IO_REG_CLK;
        if (addr[17:2] == IO_CLK_ADDR[17:2])
            return IO_REG_SNAP;
        return IO_REG_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_io_responder_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : resp_tx_fifo
// Purpose : UART transmit byte queue with occupancy and sticky drop flag.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module resp_tx_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH_DEFAULT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    push,
    input  logic [7:0]              push_data,
    input  logic                    pop,
    output logic                    head_valid,
    output logic [7:0]              head_data,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_occ;
    logic               r_ovf;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == (c_PTR_W+1)'(DEPTH));
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (push && !w_do_push)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign head_valid = !w_empty;
    assign head_data  = r_mem[r_rd_ptr];
    assign occupancy  = r_occ;
    assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/ram_io_responder.sv
//------------------------------------------------------------------------------
// Module  : ram_io_responder
// Purpose : CPU-side byte RAM plus memory-mapped UART port, stop register and
//           optional cycle counter (enabled by RESP_CYCLE_COUNTER_EN).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int TXQ_DEPTH   = TXQ_DEPTH_DEFAULT,
    parameter int FULL_MARGIN = FULL_MARGIN_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_pop,
    output logic        halt,
    output logic        txq_overflow
);

    localparam int                c_OCC_W    = $clog2(TXQ_DEPTH) + 1;
    localparam logic [c_OCC_W-1:0] c_FULL_LVL = c_OCC_W'(TXQ_DEPTH - FULL_MARGIN);

    logic              w_is_io;
    logic [ADDR_W-1:0] w_ram_addr;
    io_reg_e           w_io_sel;
    logic              w_io_rd;
    logic              w_io_wr;
    logic [7:0]        w_io_rd_data;
    logic              w_tx_push;
    logic [7:0]        w_tx_data;
    logic [c_OCC_W-1:0] w_txq_occ;
    logic              w_txq_empty;
    logic              w_unused_addr;

    logic [7:0]        r_ram [2**ADDR_W];
    logic [7:0]        r_ram_rd;
    logic              r_rd_is_ram;
    logic [7:0]        r_io_rd;
    logic              r_stop;
    logic              r_halt;

    assign w_is_io       = (cpu_a[17:16] == IO_SEL);
    assign w_ram_addr    = cpu_a[ADDR_W-1:0];
    assign w_io_sel      = decode_io(cpu_a[17:0]);
    assign w_io_rd       = w_is_io && !cpu_wr;
    assign w_io_wr       = w_is_io && cpu_wr;
    assign w_unused_addr = ^cpu_a[31:18];

    // RAM array has no reset so it maps onto block memory and survives reset.
    always_ff @(posedge clk_in) begin
        if (!w_is_io && cpu_wr)
            r_ram[w_ram_addr] <= cpu_dout;
        r_ram_rd <= r_ram[w_ram_addr];
    end

`ifdef RESP_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_cnt;
    logic [23:0] r_snap;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cycle_cnt <= '0;
            r_snap      <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_io_rd && (w_io_sel == IO_REG_CLK))
                r_snap <= r_cycle_cnt[31:8];
        end
    end
`endif

    always_comb begin
        w_io_rd_data = 8'h00;
        if (w_io_rd) begin
            case (w_io_sel)
                IO_REG_PORT: w_io_rd_data = uart_rx_valid ? uart_rx_data : 8'h00;
`ifdef RESP_CYCLE_COUNTER_EN
                IO_REG_CLK:  w_io_rd_data = r_cycle_cnt[7:0];
                IO_REG_SNAP: begin
                    case (cpu_a[1:0])
                        2'd1:    w_io_rd_data = r_snap[7:0];
                        2'd2:    w_io_rd_data = r_snap[15:8];
                        2'd3:    w_io_rd_data = r_snap[23:16];
                        default: w_io_rd_data = 8'h00;
                    endcase
                end
`endif
                default:     w_io_rd_data = 8'h00;
            endcase
        end
    end

    // Read data comes from either the RAM register or the I/O register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_is_ram <= 1'b0;
            r_io_rd     <= 8'h00;
        end else begin
            r_rd_is_ram <= !w_is_io && !cpu_wr;
            r_io_rd     <= w_io_rd_data;
        end
    end

    assign cpu_din = r_rd_is_ram ? r_ram_rd : r_io_rd;

    // Pop in the same cycle the byte is sampled so back-to-back reads never repeat it.
    assign uart_rx_pop = rst_in && w_io_rd && (w_io_sel == IO_REG_PORT) && uart_rx_valid;

    assign w_tx_push = w_io_wr && (((w_io_sel == IO_REG_PORT) && (cpu_dout != 8'h00)) ||
                                   (w_io_sel == IO_REG_CLK));
    assign w_tx_data = (w_io_sel == IO_REG_CLK) ? 8'h00 : cpu_dout;

    resp_tx_fifo #(
        .DEPTH      (TXQ_DEPTH)
    ) u_txq (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (w_tx_push),
        .push_data  (w_tx_data),
        .pop        (uart_tx_ready),
        .head_valid (uart_tx_valid),
        .head_data  (uart_tx_data),
        .occupancy  (w_txq_occ),
        .overflow   (txq_overflow)
    );

    assign w_txq_empty    = (w_txq_occ == '0);
    assign io_buffer_full = (w_txq_occ >= c_FULL_LVL);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stop <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            if (w_io_wr && (w_io_sel == IO_REG_CLK))
                r_stop <= 1'b1;
            if (r_stop && w_txq_empty)
                r_halt <= 1'b1;
        end
    end

    // Combinational term raises halt in the first drained cycle; r_halt holds it.
    assign halt = r_halt || (r_stop && w_txq_empty);

endmodule

`default_nettype wire

// File: tb/tb_ram_io_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_io_responder
// Purpose : Scoreboard bench for ram_io_responder (RAM, UART queue, halt, counter).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_pop;
    logic        halt;
    logic        txq_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_rd[$];
    logic [7:0] q_tx[$];

`ifdef RESP_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    ram_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_pop    (uart_rx_pop),
        .halt           (halt),
        .txq_overflow   (txq_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted UART byte must match the next expected byte in order.
    always @(negedge clk_in) begin
        if (rst_in && uart_tx_valid && uart_tx_ready) begin
            if (q_tx.size() == 0)
                check_eq("tx_sb_depth", q_tx.size(), 1);
            else
                check_eq("tx_data", uart_tx_data, q_tx.pop_front());
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = 1'b1;
        cpu_dout = d;
        if ((a[17:0] == 18'h30000 && d != 8'h00) || a[17:0] == 18'h30004) begin
            if (q_tx.size() < 8)
                q_tx.push_back(a[2] ? 8'h00 : d);
        end
        @(posedge clk_in);
        #1;
        cpu_wr   = 1'b0;
        cpu_a    = '0;
        cpu_dout = '0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
        cpu_a  = a;
        cpu_wr = 1'b0;
        q_rd.push_back(exp);
        #1;
        check_eq({tag, "_pop"}, uart_rx_pop, (a[17:0] == 18'h30000) && uart_rx_valid);
        @(posedge clk_in);
        #1;
        check_eq(tag, cpu_din, q_rd.pop_front());
        cpu_a = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in        = 1'b0;
        cpu_a         = '0;
        cpu_wr        = 1'b0;
        cpu_dout      = '0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;

        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_cpu_din",  cpu_din,        0);
        check_eq("rst_tx_valid", uart_tx_valid,  0);
        check_eq("rst_rx_pop",   uart_rx_pop,    0);
        check_eq("rst_halt",     halt,           0);
        check_eq("rst_ovf",      txq_overflow,   0);
        check_eq("rst_full",     io_buffer_full, 0);

        // Counter equals the number of rising edges since release.
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (32'h1234) @(posedge clk_in);
        #1;
        cpu_read(32'h0003_0004, CNT_EN ? 8'h34 : 8'h00, "clk_b0");
        cpu_read(32'h0003_0005, CNT_EN ? 8'h12 : 8'h00, "clk_b1");
        cpu_read(32'h0003_0006, 8'h00, "clk_b2");

        cpu_write(32'h0000_0010, 8'hA5);
        cpu_read(32'h0000_0010, 8'hA5, "ram_rd_after_wr");
        cpu_write(32'h0001_FFFF, 8'h3C);
        cpu_write(32'h0000_0020, 8'h5A);
        cpu_read(32'h0001_FFFF, 8'h3C, "ram_top");
        cpu_read(32'h0002_0020, 8'h5A, "ram_wrap");
        cpu_read(32'h0003_0008, 8'h00, "io_unmapped");
        cpu_write(32'h0003_0008, 8'h99);
        check_eq("unmapped_wr_valid", uart_tx_valid, 0);

        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        cpu_read(32'h0003_0000, 8'h77, "rx_data");
        uart_rx_valid = 1'b0;
        cpu_read(32'h0003_0000, 8'h00, "rx_empty");

        cpu_write(32'h0003_0000, 8'h00);
        @(posedge clk_in);
        #1;
        check_eq("zero_wr_valid", uart_tx_valid, 0);

        // Fill with the UART stalled, then overrun.
        for (int i = 1; i <= 9; i++) begin
            cpu_write(32'h0003_0000, 8'h48);
            if (i == 5) check_eq("full_at5", io_buffer_full, 0);
            if (i == 6) check_eq("full_at6", io_buffer_full, 1);
            if (i == 8) check_eq("ovf_at8",  txq_overflow,   0);
        end
        check_eq("ovf_at9", txq_overflow, 1);
        check_eq("occ_at9", dut.w_txq_occ, 8);

        uart_tx_ready = 1'b1;
        for (int k = 0; k < 40 && q_tx.size() != 0; k++) @(posedge clk_in);
        #1;
        check_eq("drain_left",   q_tx.size(),   0);
        check_eq("drain_valid",  uart_tx_valid, 0);
        check_eq("ovf_sticky",   txq_overflow,  1);
        check_eq("drain_full",   io_buffer_full, 0);
        uart_tx_ready = 1'b0;

        // Asynchronous reset with bytes pending discards them.
        cpu_write(32'h0003_0000, 8'h31);
        cpu_write(32'h0003_0000, 8'h32);
        cpu_write(32'h0003_0000, 8'h33);
        check_eq("pre_rst_valid", uart_tx_valid, 1);
        #2;
        rst_in = 1'b0;
        #1;
        check_eq("rst_async_valid", uart_tx_valid, 0);
        q_tx.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_eq("post_rst_occ",   dut.w_txq_occ, 0);
        check_eq("post_rst_halt",  halt,          0);
        check_eq("post_rst_ovf",   txq_overflow,  0);
        check_eq("post_rst_valid", uart_tx_valid, 0);

        uart_tx_ready = 1'b1;
        cpu_write(32'h0003_0000, 8'h41);
        cpu_write(32'h0003_0004, 8'h55);
        check_eq("halt_pre",       halt,          0);
        check_eq("stop_byte_vld",  uart_tx_valid, 1);
        @(posedge clk_in);
        #1;
        check_eq("halt_rise",      halt,          1);
        check_eq("halt_tx_valid",  uart_tx_valid, 0);
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("halt_sticky",    halt,          1);
        check_eq("tx_leftover",    q_tx.size(),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_io_responder.md
RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 17: RAM byte-address width, 2^ADDR_W bytes.
- TXQ_DEPTH, default 8, power of two: depth of the UART transmit queue.
- FULL_MARGIN, default 2: free slots left when io_buffer_full asserts.

REQ-002 Ports SHALL be as follows. One clock; reset is asynchronous and active-low.
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- cpu_a  in  32  byte address from CPU (bits 17:0 decoded)
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU
- io_buffer_full  out  1  transmit queue nearly full
- uart_tx_valid  out  1  transmit byte valid
- uart_tx_data  out  8  transmit byte
- uart_tx_ready  in  1  UART accepts byte
- uart_rx_valid  in  1  received byte available
- uart_rx_data  in  8  received byte
- uart_rx_pop  out  1  one-cycle pop of the received byte
- halt  out  1  program stopped and queue drained
- txq_overflow  out  1  sticky: a write was dropped because the queue was full

Function
REQ-003 Decode SHALL treat cpu_a[17:16]==2'b11 as I/O and every other address as RAM at cpu_a[ADDR_W-1:0]; RAM addresses SHALL wrap modulo 2^ADDR_W.
REQ-004 A RAM write (cpu_wr=1) SHALL update the addressed byte at the same clock edge, with no stall.
REQ-005 A RAM read SHALL drive cpu_din with the addressed byte exactly one cycle after the address, via a registered output.
REQ-006 A read presented in the cycle directly after a write to the same address SHALL return the newly written byte.
REQ-007 A write of a nonzero byte to 0x30000 SHALL push that byte into the transmit queue; a write of 0x00 to 0x30000 SHALL be ignored.
REQ-008 A write to 0x30004 (data ignored) SHALL push 0x00 into the transmit queue and set an internal stop flag; the stop flag is sticky until reset.
REQ-009 halt SHALL assert in the first cycle in which the stop flag is set and the transmit queue is empty, and SHALL remain high until reset.
REQ-010 The transmit queue head SHALL drive uart_tx_valid/uart_tx_data.
REQ-011 A queue entry SHALL pop on a cycle with uart_tx_valid && uart_tx_ready.
REQ-012 A push and a pop in the same cycle SHALL both succeed; occupancy is then unchanged.
REQ-013 io_buffer_full SHALL equal (occupancy >= TXQ_DEPTH-FULL_MARGIN), computed combinationally from registered occupancy.
REQ-014 A push into a full queue with no simultaneous pop SHALL be dropped and SHALL set txq_overflow.
REQ-015 A read of 0x30000 SHALL return uart_rx_data on cpu_din in the next cycle and pulse uart_rx_pop when uart_rx_valid=1; otherwise it SHALL return 0x00 with no pop.
REQ-016 A read of 0x30004 SHALL return cycle-counter byte 0 and snapshot counter bits 31:8; reads of 0x30005..0x30007 SHALL return the snapshot bytes 1..3.
REQ-017 The cycle counter SHALL be 32 bits, SHALL start at 0 after reset, SHALL increment every cycle, and SHALL wrap at 2^32.
REQ-018 Reads of any other I/O address SHALL return 0x00; writes to any other I/O address SHALL be ignored.

Reset
REQ-019 While rst_in=0, the following SHALL be cleared asynchronously: cpu_din=0, uart_tx_valid=0, uart_rx_pop=0, halt=0, txq_overflow=0, queue occupancy=0, counter=0, snapshot=0, stop flag=0.
REQ-020 RAM contents SHALL NOT be cleared by reset.
REQ-021 A reset asserted while the queue is non-empty SHALL discard every queued byte.

Configuration
REQ-022 With RESP_CYCLE_COUNTER_EN defined, the counter and snapshot SHALL be built and behave per REQ-016/017.
REQ-023 Without RESP_CYCLE_COUNTER_EN, no counter or snapshot logic SHALL exist, and reads of 0x30004..0x30007 SHALL return 0x00.

Structure
REQ-024 A shared package SHALL hold:
- IO_SEL=2'b11
- IO_PORT_ADDR=18'h30000
- IO_CLK_ADDR=18'h30004
- the defaults for TXQ_DEPTH and FULL_MARGIN
REQ-025 The transmit queue SHALL be one sub-module, resp_tx_fifo, with push/pop/occupancy ports; RAM and decode SHALL live in the top module.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Write 0xA5 to 0x00010, then read 0x00010 in the next cycle -> cpu_din=0xA5 one cycle later.
- With uart_tx_ready=0 and defaults, write 'H' six times to 0x30000 -> io_buffer_full=1 after the sixth push; three more writes -> txq_overflow=1 and occupancy=8.
- Write 0x00 to 0x30000 -> no push, uart_tx_valid stays 0.
- Write 0x41 to 0x30000, then any byte to 0x30004, with uart_tx_ready=1 -> UART sees 0x41 then 0x00; halt rises the cycle after the queue empties.
- With RESP_CYCLE_COUNTER_EN defined, read 0x30004 at cycle 0x1234 after reset, then 0x30005 -> bytes 0x34 and 0x12; undefined -> 0x00 and 0x00.
- Pull rst_in low with 3 bytes queued -> uart_tx_valid=0 immediately; after release, occupancy=0 and halt=0.
